// File: rtl/tail_light_decoder_pkg.sv
// Shared types and pattern constants for the tail-light receive-side decoder.
package tail_light_pkg;

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_TURN   = 3'd1,
        MODE_BRAKE  = 3'd2,
        MODE_FOG    = 3'd3,
        MODE_HAZARD = 3'd4,
        MODE_ERROR  = 3'd7
    } lamp_mode_t;

    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_1   = 3'b100;
    localparam logic [2:0] PAT_2   = 3'b110;
    localparam logic [2:0] PAT_ALL = 3'b111;

    localparam logic [3:0] RUN_MAX = 4'd15;

    function automatic logic is_legal(input logic [2:0] pattern);
        logic ok;
        case (pattern)
            PAT_OFF, PAT_1, PAT_2, PAT_ALL: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tail_light_decoder_side.sv
// Single-side lamp classifier: tracks the previous pattern, its run length,
// the current lamp mode and the completed turn-sweep count.
module lamp_side_decoder
    import tail_light_pkg::*;
#(
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       pattern,
    output lamp_mode_t       mode,
    output lamp_mode_t       mode_next,
    output logic [CNT_W-1:0] turns,
    output logic             illegal
);

    localparam logic [3:0] HOLD_RUN = 4'(HOLD);

    logic [2:0]       prev_q;
    logic [3:0]       run_q;
    logic [3:0]       run_next;
    lamp_mode_t       mode_q;
    logic [CNT_W-1:0] turns_q;
    logic             turn_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= PAT_OFF;
            run_q   <= 4'd0;
            mode_q  <= MODE_OFF;
            turns_q <= '0;
        end else begin
            prev_q <= pattern;
            run_q  <= run_next;
            mode_q <= mode_next;
            if (turn_hit) begin
                turns_q <= turns_q + 1'b1;
            end
        end
    end

    // Rules are ordered: transitions take priority over steady-hold classification,
    // and a steady pattern only classifies on the exact cycle its run reaches HOLD.
    always_comb begin
        illegal   = !is_legal(pattern);
        run_next  = (pattern == prev_q) ? ((run_q == RUN_MAX) ? RUN_MAX : run_q + 4'd1) : 4'd1;
        mode_next = mode_q;
        turn_hit  = 1'b0;

        if (illegal) begin
            mode_next = MODE_ERROR;
        end else if (prev_q == PAT_OFF && pattern == PAT_ALL) begin
            mode_next = MODE_HAZARD;
        end else if (prev_q == PAT_ALL && pattern == PAT_OFF && mode_q == MODE_HAZARD) begin
            mode_next = MODE_HAZARD;
        end else if ((prev_q == PAT_1 && pattern == PAT_2) ||
                     (prev_q == PAT_2 && pattern == PAT_ALL)) begin
            mode_next = MODE_TURN;
        end else if (prev_q == PAT_ALL && pattern == PAT_OFF && mode_q == MODE_TURN) begin
            mode_next = MODE_TURN;
            turn_hit  = 1'b1;
        end else if (run_next == HOLD_RUN) begin
            // A steady 110 never happens in a legal sweep, so it classifies as ERROR.
            case (pattern)
                PAT_ALL: mode_next = MODE_BRAKE;
                PAT_1:   mode_next = MODE_FOG;
                PAT_OFF: mode_next = MODE_OFF;
                PAT_2:   mode_next = MODE_ERROR;
                default: mode_next = mode_q;
            endcase
        end
    end

    assign mode  = mode_q;
    assign turns = turns_q;

endmodule

// File: rtl/tail_light_decoder.sv
// Tail-light monitor top: two independent side decoders plus shared hazard and error flags.
module tail_light_decoder
    import tail_light_pkg::*;
#(
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             la,
    input  logic             lb,
    input  logic             lc,
    input  logic             ra,
    input  logic             rb,
    input  logic             rc,
    output logic [2:0]       left_mode,
    output logic [2:0]       right_mode,
    output logic [CNT_W-1:0] left_turns,
    output logic [CNT_W-1:0] right_turns,
    output logic             hazard,
    output logic             err_pulse,
    output logic             err_sticky
);

    lamp_mode_t left_mode_q;
    lamp_mode_t right_mode_q;
    lamp_mode_t left_mode_n;
    lamp_mode_t right_mode_n;
    logic       left_illegal;
    logic       right_illegal;
    logic       hazard_q;
    logic       err_pulse_q;
    logic       err_sticky_q;

    lamp_side_decoder #(.HOLD(HOLD), .CNT_W(CNT_W)) u_left (
        .clk       (clk),
        .reset     (reset),
        .pattern   ({la, lb, lc}),
        .mode      (left_mode_q),
        .mode_next (left_mode_n),
        .turns     (left_turns),
        .illegal   (left_illegal)
    );

    lamp_side_decoder #(.HOLD(HOLD), .CNT_W(CNT_W)) u_right (
        .clk       (clk),
        .reset     (reset),
        .pattern   ({ra, rb, rc}),
        .mode      (right_mode_q),
        .mode_next (right_mode_n),
        .turns     (right_turns),
        .illegal   (right_illegal)
    );

    // Flags are built from next-state values so they line up with the registered modes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hazard_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            hazard_q     <= (left_mode_n == MODE_HAZARD) && (right_mode_n == MODE_HAZARD);
            err_pulse_q  <= left_illegal || right_illegal;
            err_sticky_q <= err_sticky_q || left_illegal || right_illegal;
        end
    end

    assign left_mode  = left_mode_q;
    assign right_mode = right_mode_q;
    assign hazard     = hazard_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_tail_light_decoder.sv
// Directed, table-driven bench for tail_light_decoder with hand-computed expectations.
module tb_tail_light_decoder;

    logic       clk;
    logic       reset;
    logic       la, lb, lc, ra, rb, rc;
    logic [2:0] left_mode, right_mode;
    logic [7:0] left_turns, right_turns;
    logic       hazard, err_pulse, err_sticky;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] pl;
        logic [2:0] pr;
        logic [2:0] lm;
        logic [2:0] rm;
        logic [7:0] lt;
        logic [7:0] rt;
        logic       hz;
        logic       ep;
        logic       es;
    } vec_t;

    vec_t vecs[$];

    tail_light_decoder #(.HOLD(3), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .la          (la),
        .lb          (lb),
        .lc          (lc),
        .ra          (ra),
        .rb          (rb),
        .rc          (rc),
        .left_mode   (left_mode),
        .right_mode  (right_mode),
        .left_turns  (left_turns),
        .right_turns (right_turns),
        .hazard      (hazard),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic addVec(input string name, input logic rst, input logic [2:0] pl, input logic [2:0] pr,
                          input logic [2:0] lm, input logic [2:0] rm, input logic [7:0] lt, input logic [7:0] rt,
                          input logic hz, input logic ep, input logic es);
        vec_t v;
        v.name = name; v.rst = rst; v.pl = pl; v.pr = pr;
        v.lm = lm; v.rm = rm; v.lt = lt; v.rt = rt;
        v.hz = hz; v.ep = ep; v.es = es;
        vecs.push_back(v);
    endtask

    // Inputs change #1 after the edge; outputs are sampled #1 after the next edge.
    task automatic applyStimulus(input logic rst, input logic [2:0] pl, input logic [2:0] pr);
        reset = rst;
        {la, lb, lc} = pl;
        {ra, rb, rc} = pr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] lm, input logic [2:0] rm,
                               input logic [7:0] lt, input logic [7:0] rt,
                               input logic hz, input logic ep, input logic es);
        checks++;
        if ({left_mode, right_mode, left_turns, right_turns, hazard, err_pulse, err_sticky} !==
            {lm, rm, lt, rt, hz, ep, es}) begin
            fails++;
            $display("[TB] FAIL %s: got lm=%0d rm=%0d lt=%0d rt=%0d hz=%0b ep=%0b es=%0b, expected lm=%0d rm=%0d lt=%0d rt=%0d hz=%0b ep=%0b es=%0b",
                     name, left_mode, right_mode, left_turns, right_turns, hazard, err_pulse, err_sticky,
                     lm, rm, lt, rt, hz, ep, es);
        end
    endtask

    task automatic doSweep();
        applyStimulus(1'b0, 3'b100, 3'b000);
        applyStimulus(1'b0, 3'b110, 3'b000);
        applyStimulus(1'b0, 3'b111, 3'b000);
        applyStimulus(1'b0, 3'b000, 3'b000);
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        {la, lb, lc, ra, rb, rc} = 6'b0;

        // name, rst, pL, pR, lm, rm, lt, rt, hz, ep, es
        addVec("reset",        1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        addVec("turn1_100",    0, 3'b100, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        addVec("turn1_110",    0, 3'b110, 3'b000, 1, 0, 0, 0, 0, 0, 0);
        addVec("turn1_111",    0, 3'b111, 3'b000, 1, 0, 0, 0, 0, 0, 0);
        addVec("turn1_000",    0, 3'b000, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        addVec("turn2_100",    0, 3'b100, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        addVec("turn2_110",    0, 3'b110, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        addVec("turn2_111",    0, 3'b111, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        addVec("turn2_000",    0, 3'b000, 3'b000, 1, 0, 2, 0, 0, 0, 0);
        addVec("reset2",       1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        addVec("brake_pre",    0, 3'b100, 3'b100, 0, 0, 0, 0, 0, 0, 0);
        addVec("brake_s1",     0, 3'b111, 3'b111, 0, 0, 0, 0, 0, 0, 0);
        addVec("brake_s2",     0, 3'b111, 3'b111, 0, 0, 0, 0, 0, 0, 0);
        addVec("brake_s3",     0, 3'b111, 3'b111, 2, 2, 0, 0, 0, 0, 0);
        addVec("reset3",       1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        addVec("haz_111a",     0, 3'b111, 3'b111, 4, 4, 0, 0, 1, 0, 0);
        addVec("haz_000a",     0, 3'b000, 3'b000, 4, 4, 0, 0, 1, 0, 0);
        addVec("haz_111b",     0, 3'b111, 3'b111, 4, 4, 0, 0, 1, 0, 0);
        addVec("haz_000b",     0, 3'b000, 3'b000, 4, 4, 0, 0, 1, 0, 0);
        addVec("haz_111c",     0, 3'b111, 3'b111, 4, 4, 0, 0, 1, 0, 0);
        addVec("haz_000c",     0, 3'b000, 3'b000, 4, 4, 0, 0, 1, 0, 0);
        addVec("reset4",       1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        addVec("fog_s1",       0, 3'b100, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        addVec("fog_s2",       0, 3'b100, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        addVec("fog_s3",       0, 3'b100, 3'b000, 3, 0, 0, 0, 0, 0, 0);
        addVec("fog_s4",       0, 3'b100, 3'b000, 3, 0, 0, 0, 0, 0, 0);
        addVec("fog_111",      0, 3'b111, 3'b000, 3, 0, 0, 0, 0, 0, 0);
        addVec("fog_000_1",    0, 3'b000, 3'b000, 3, 0, 0, 0, 0, 0, 0);
        addVec("fog_000_2",    0, 3'b000, 3'b000, 3, 0, 0, 0, 0, 0, 0);
        addVec("fog_000_3",    0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        addVec("rerr_100",     0, 3'b000, 3'b100, 0, 0, 0, 0, 0, 0, 0);
        addVec("rerr_110",     0, 3'b000, 3'b110, 0, 1, 0, 0, 0, 0, 0);
        addVec("rerr_010",     0, 3'b000, 3'b010, 0, 7, 0, 0, 0, 1, 1);
        addVec("rerr_after",   0, 3'b000, 3'b100, 0, 7, 0, 0, 0, 0, 1);
        addVec("rerr_turn",    0, 3'b000, 3'b110, 0, 1, 0, 0, 0, 0, 1);
        addVec("rerr_111",     0, 3'b000, 3'b111, 0, 1, 0, 0, 0, 0, 1);
        addVec("rerr_000",     0, 3'b000, 3'b000, 0, 1, 0, 1, 0, 0, 1);
        addVec("dual_illegal", 0, 3'b011, 3'b101, 7, 7, 0, 1, 0, 1, 1);
        addVec("dual_after1",  0, 3'b000, 3'b000, 7, 7, 0, 1, 0, 0, 1);
        addVec("dual_after2",  0, 3'b000, 3'b000, 7, 7, 0, 1, 0, 0, 1);
        addVec("dual_off",     0, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 1);
        addVec("steady110_1",  0, 3'b110, 3'b000, 0, 0, 0, 1, 0, 0, 1);
        addVec("steady110_2",  0, 3'b110, 3'b000, 0, 0, 0, 1, 0, 0, 1);
        addVec("steady110_3",  0, 3'b110, 3'b000, 7, 0, 0, 1, 0, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].pl, vecs[i].pr);
            checkOutput(vecs[i].name, vecs[i].lm, vecs[i].rm, vecs[i].lt, vecs[i].rt,
                        vecs[i].hz, vecs[i].ep, vecs[i].es);
        end

        // Left leaves ERROR through a sweep and counts five sweeps.
        for (int k = 1; k <= 5; k++) begin
            doSweep();
            checkOutput($sformatf("sweep_%0d", k), 3'd1, 3'd0, 8'(k), 8'd1, 1'b0, 1'b0, 1'b1);
        end

        applyStimulus(1'b1, 3'b000, 3'b000);
        checkOutput("reset_mid_turn", 3'd0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        for (int k = 1; k <= 255; k++) begin
            doSweep();
        end
        checkOutput("sweeps_255", 3'd1, 3'd0, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
        doSweep();
        checkOutput("sweeps_wrap", 3'd1, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
